// File: rtl/fft_pkg.sv
// Shared FFT pipeline definitions: index bit reversal, ceil-log2 helper and
// the reorder-stage FSM state type.
package fft_pkg;

  // Widest index supported by bitrev (N up to 4096).
  localparam int MAX_LOG_N = 12;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } reorder_state_e;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return result;
  endfunction

  // Reverses the low log_n bits of value; the upper bits of the result are zero.
  function automatic logic [MAX_LOG_N-1:0] bitrev(input logic [MAX_LOG_N-1:0] value,
                                                  input int log_n);
    logic [MAX_LOG_N-1:0] rev;
    logic [MAX_LOG_N-1:0] rest;
    rev  = '0;
    rest = value;
    for (int b = 0; b < MAX_LOG_N; b++) begin
      if (b < log_n) begin
        rev  = {rev[MAX_LOG_N-2:0], rest[0]};
        rest = rest >> 1;
      end
    end
    return rev;
  endfunction

endpackage

// File: rtl/reorder_ram.sv
// Simple dual-port RAM with a registered read port and no reset, kept as its
// own module so synthesis can map it onto block RAM.
module reorder_ram #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bit_reverse_buffer.sv
// Ping-pong reorder buffer turning bit-reversed FFT frames into natural order.
// Define BITREV_BUF_SIMX_EN to drive odata_r/odata_i to X while odata_en is low.
//
//   state | meaning
//   IDLE  | no full bank; first read issued the cycle a bank becomes full
//   READ  | streaming bank rbank in natural order, one word per cycle
module bit_reverse_buffer
  import fft_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             idata_en,
  input  logic [WIDTH-1:0] idata_r,
  input  logic [WIDTH-1:0] idata_i,
  output logic             odata_en,
  output logic [WIDTH-1:0] odata_r,
  output logic [WIDTH-1:0] odata_i
);

  localparam int LOG_N = clog2(N);
  localparam int AW    = LOG_N + 1;
  localparam int DW    = 2 * WIDTH;
  localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);

  // Writer
  logic [LOG_N-1:0] wcnt_q, wcnt_d;
  logic             wbank_q, wbank_d;
  logic             wwrap;
  logic [AW-1:0]    waddr;

  // Reader
  reorder_state_e   state_q, state_d;
  logic [LOG_N-1:0] rcnt_q, rcnt_d;
  logic             rbank_q, rbank_d;
  logic             rd_en;
  logic             rd_done;
  logic [AW-1:0]    raddr;

  logic [1:0]       full_q, full_d;

  // Output pipeline
  logic             rd_vld_q;
  logic             oen_q;
  logic [DW-1:0]    rdata;
  logic [DW-1:0]    odata_q;

  assign wwrap = idata_en && (wcnt_q == LAST);
  assign waddr = {wbank_q, LOG_N'(bitrev(MAX_LOG_N'(wcnt_q), LOG_N))};

  always_comb begin
    wcnt_d  = wcnt_q;
    wbank_d = wbank_q;
    if (idata_en) begin
      wcnt_d = wcnt_q + LOG_N'(1);
      if (wwrap) begin
        wbank_d = ~wbank_q;
      end
    end
  end

  // The IDLE->READ transition issues the read of word 0 itself, so the first
  // output lands two edges after the bank fills.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rbank_d = rbank_q;
    rd_en   = 1'b0;
    rd_done = 1'b0;
    raddr   = {rbank_q, rcnt_q};
    case (state_q)
      IDLE: begin
        if (full_q[rbank_q]) begin
          rd_en   = 1'b1;
          raddr   = {rbank_q, {LOG_N{1'b0}}};
          rcnt_d  = LOG_N'(1);
          state_d = READ;
        end
      end
      READ: begin
        rd_en  = 1'b1;
        rcnt_d = rcnt_q + LOG_N'(1);
        if (rcnt_q == LAST) begin
          rd_done = 1'b1;
          rbank_d = ~rbank_q;
          if (!(full_q[~rbank_q] || (wwrap && (wbank_q == ~rbank_q)))) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    full_d = full_q;
    if (rd_done) begin
      full_d[rbank_q] = 1'b0;
    end
    if (wwrap) begin
      full_d[wbank_q] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt_q   <= '0;
      wbank_q  <= 1'b0;
      state_q  <= IDLE;
      rcnt_q   <= '0;
      rbank_q  <= 1'b0;
      full_q   <= 2'b00;
      rd_vld_q <= 1'b0;
      oen_q    <= 1'b0;
      odata_q  <= '0;
    end else begin
      wcnt_q   <= wcnt_d;
      wbank_q  <= wbank_d;
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      rbank_q  <= rbank_d;
      full_q   <= full_d;
      rd_vld_q <= rd_en;
      oen_q    <= rd_vld_q;
      if (rd_vld_q) begin
        odata_q <= rdata;
      end
    end
  end

  reorder_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clock   (clock),
    .we_i    (idata_en),
    .waddr_i (waddr),
    .wdata_i ({idata_r, idata_i}),
    .re_i    (rd_en),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign odata_en = oen_q;

`ifdef BITREV_BUF_SIMX_EN
  assign odata_r = oen_q ? odata_q[DW-1:WIDTH] : {WIDTH{1'bx}};
  assign odata_i = oen_q ? odata_q[WIDTH-1:0]  : {WIDTH{1'bx}};
`else
  assign odata_r = odata_q[DW-1:WIDTH];
  assign odata_i = odata_q[WIDTH-1:0];
`endif

endmodule

// File: tb/tb_bit_reverse_buffer.sv
// Directed and randomized bench for bit_reverse_buffer (N=16, WIDTH=16) with a
// frame-level reference model that schedules each reordered frame in time.
module tb_bit_reverse_buffer;

  localparam int N = 16;
  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         idata_en;
  logic [W-1:0] idata_r;
  logic [W-1:0] idata_i;
  logic         odata_en;
  logic [W-1:0] odata_r;
  logic [W-1:0] odata_i;

  always #5 clock = ~clock;

  bit_reverse_buffer #(
    .WIDTH (W),
    .N     (N)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .idata_en (idata_en),
    .idata_r  (idata_r),
    .idata_i  (idata_i),
    .odata_en (odata_en),
    .odata_r  (odata_r),
    .odata_i  (odata_i)
  );

  typedef struct {
    int           t;
    logic [W-1:0] r;
    logic [W-1:0] i;
  } exp_t;

  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  exp_t         exp_q[$];
  logic [W-1:0] fr_r[N];
  logic [W-1:0] fr_i[N];
  int           wk = 0;
  int           next_free = 0;
  logic [W-1:0] last_r = '0;
  logic [W-1:0] last_i = '0;
  logic [W-1:0] cap_q[$];
  int           first_out = -1;
  logic         prev_en = 1'b0;
  int           run = 0;
  int           last_run = 0;
  int           t_last_in = 0;
  int           tl;
  logic [W-1:0] nat[N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  function automatic int brev(input int n);
    int r;
    int v;
    r = 0;
    v = n;
    for (int b = 0; b < 4; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, expv, cyc);
    end
  endtask

  task automatic sample_out();
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
      e = exp_q.pop_front();
      chk("odata_en", {15'd0, odata_en}, 16'd1);
      chk("odata_r", odata_r, e.r);
      chk("odata_i", odata_i, e.i);
      last_r = e.r;
      last_i = e.i;
    end else begin
      chk("odata_en_idle", {15'd0, odata_en}, 16'd0);
`ifdef BITREV_BUF_SIMX_EN
      chk("odata_r_idle", odata_r, {W{1'bx}});
      chk("odata_i_idle", odata_i, {W{1'bx}});
`else
      chk("odata_r_idle", odata_r, last_r);
      chk("odata_i_idle", odata_i, last_i);
`endif
    end
    if (odata_en === 1'b1) begin
      cap_q.push_back(odata_r);
      if (!prev_en) first_out = cyc;
      run++;
    end else begin
      if (run > 0) last_run = run;
      run = 0;
    end
    prev_en = (odata_en === 1'b1);
  endtask

  task automatic step(input logic rst, input logic en, input logic [W-1:0] r, input logic [W-1:0] i);
    int start;
    reset    = rst;
    idata_en = en;
    idata_r  = r;
    idata_i  = i;
    @(posedge clock);
    cyc++;
    if (rst) begin
      exp_q.delete();
      wk = 0;
      next_free = 0;
      last_r = '0;
      last_i = '0;
    end else if (en) begin
      fr_r[wk] = r;
      fr_i[wk] = i;
      t_last_in = cyc;
      wk++;
      if (wk == N) begin
        wk = 0;
        start = (cyc + 2 > next_free) ? cyc + 2 : next_free;
        for (int n = 0; n < N; n++)
          exp_q.push_back('{t: start + n, r: fr_r[brev(n)], i: fr_i[brev(n)]});
        next_free = start + N;
      end
    end
    #1;
    sample_out();
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) step(1'b0, 1'b0, W'($urandom), W'($urandom));
  endtask

  task automatic rand_frames(input int frames);
    for (int c = 0; c < frames * N; c++) step(1'b0, 1'b1, W'($urandom), W'($urandom));
  endtask

  initial begin
    reset = 1'b1;
    idata_en = 1'b0;
    idata_r = '0;
    idata_i = '0;
    step(1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, '0);
    idle(2);

    // Single ramp frame
    cap_q.delete();
    for (int k = 0; k < N; k++) step(1'b0, 1'b1, W'(k), W'(-k));
    tl = t_last_in;
    idle(22);
    chk("s1_count", W'(cap_q.size()), W'(N));
    for (int k = 0; k < N; k++) chk("s1_order", cap_q[k], nat[k]);
    chk("s1_latency", W'(first_out - tl), 16'd2);

    // Three back-to-back frames
    rand_frames(3);
    idle(22);
    chk("s2_run", W'(last_run), 16'd48);

    // Ramp frame with a 5-cycle gap after sample 7
    cap_q.delete();
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, W'(k), W'(-k));
    idle(5);
    for (int k = 8; k < N; k++) step(1'b0, 1'b1, W'(k), W'(-k));
    tl = t_last_in;
    idle(22);
    chk("s3_count", W'(cap_q.size()), W'(N));
    for (int k = 0; k < N; k++) chk("s3_order", cap_q[k], nat[k]);
    chk("s3_latency", W'(first_out - tl), 16'd2);

    // Reset after sample 9, then a fresh frame
    cap_q.delete();
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, W'($urandom), W'($urandom));
    step(1'b1, 1'b0, '0, '0);
    rand_frames(1);
    idle(22);
    chk("s4_count", W'(cap_q.size()), W'(N));

    // Second frame completes as the reader finishes the first
    rand_frames(2);
    idle(22);
    chk("s5_run", W'(last_run), 16'd32);

    // Random valid pattern
    for (int c = 0; c < 160; c++)
      step(1'b0, ($urandom_range(3, 0) != 0), W'($urandom), W'($urandom));
    idle(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
